wsp_tap_ctrl: RTL
=================

# wsp_tap_ctrl

Wrapper serial port controller sitting directly upstream of the wrapper instruction register. It walks a 16-state IEEE 1149.1 TAP state machine, clocked by WRCK and driven by a TMS input. From that state machine it produces the capture/shift/update strobes and SelectWIR for the WIR and for the wrapper data registers (WBY/WBR). It also steers TDI into the selected chain and multiplexes that chain's serial output onto a registered wso.

## Interface
- CNT_W, 8, width of the shift-bit counter (saturating)
- WRCK  input  1  wrapper clock; all state updates on rising edge
- WRSTN  input  1  asynchronous active-low reset
- tms  input  1  mode select, sampled on rising WRCK
- wsi  input  1  serial data in
- wir_so  input  1  serial out of the WIR chain
- wdr_so  input  1  serial out of the currently selected data register (WBY/WBR)
- select_wir  output  1  high in the IR-column states
- wir_si  output  1  equals wsi
- wir_capture, wir_shift, wir_update  output  1 each  WIR strobes
- wdr_si  output  1  equals wsi
- wdr_capture, wdr_shift, wdr_update  output  1 each  data-register strobes
- resetn  output  1  drives the WIR resetn input (see Configuration)
- wso  output  1  registered serial out
- wso_en  output  1  registered output enable for wso
- shift_count  output  CNT_W  bits shifted in the current Shift-xR visit
- tap_state  output  4  current state encoding, for debug

## Operation
- States use standard 1149.1 names and encodings:
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- Transitions are standard TAP:
  - TLR: tms=0 goes to RTI, else stays.
  - RTI: tms=1 goes to SelDR.
  - SelDR: tms=1 goes to SelIR, else CapDR.
  - SelIR: tms=1 goes to TLR, else CapIR.
  - Cap: tms=1 goes to Ex1, else Sh.
  - Sh: tms=1 goes to Ex1, else stays.
  - Ex1: tms=1 goes to Upd, else Pau.
  - Pau: tms=1 goes to Ex2.
  - Ex2: tms=1 goes to Upd, else Sh.
  - Upd: tms=1 goes to SelDR, else RTI.
- Five consecutive tms=1 reach TLR from any state.
- Strobes are Moore outputs, decoded combinationally from the state register:
  - wir_capture = (state==CapIR); wir_shift = (state==ShIR); wir_update = (state==UpdIR).
  - wdr_* are the same decodes on the DR column.
  - The target register acts on the rising WRCK edge that ends the state.
- select_wir is 1 in SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR and UpdIR; 0 otherwise.
- Serial output path:
  - wso is registered from (select_wir ? wir_so : wdr_so) on every rising edge where state is ShIR or ShDR; otherwise wso holds its value.
  - wso_en is registered from (state==ShIR || state==ShDR).
- shift_count:
  - Cleared on entering CapIR or CapDR.
  - Incremented on each rising edge spent in a Sh state.
  - Saturates at 2^CNT_W-1.
  - Holds through Pause and Exit; holds after Update until the next Capture.

## Timing
- Reset (WRSTN low, asynchronous):
  - state=TLR, wso=0, wso_en=0, shift_count=0.
  - All strobes 0, select_wir=0, resetn per Configuration.
- Reset deassertion is synchronised internally with a two-flop release on WRCK. The state machine leaves TLR no earlier than the second rising edge after WRSTN rises.
- Strobe latency: strobes assert in the cycle after the rising edge that enters the state. Capture and Update states are one cycle each unless tms holds.
- wso latency is one WRCK cycle from the chain's so. The first valid wso bit is driven in the cycle after the first ShxR edge.
- Reset asserted mid-scan: all outputs go to reset values immediately. No update strobe is emitted.

## Configuration
- WSP_TLR_RESETN_EN defined: resetn = ~(state==TLR) while synchronised reset is released, and 0 during WRSTN assertion. TMS-driven TLR therefore clears the WIR.
- WSP_TLR_RESETN_EN undefined: resetn is constant 1. Only WRSTN resets the WIR.

## Test plan
- Power-up: WRSTN low 3 cycles, then high with tms=1 -> tap_state=F, all strobes 0, wso_en=0, shift_count=0.
- IR scan: from TLR, tms sequence 0,1,1,0,0 -> tap_state=A, select_wir=1, wir_shift=1. Shift 12 bits with tms=0 x11 then 1 -> shift_count=12, wir_update high for exactly one cycle after tms 1.
- DR scan with pause: from RTI, tms 1,0,0,0,1,0,1,0,1,1 -> wdr_capture pulses once, wdr_shift high in both ShDR visits, shift_count continues across PauDR, wdr_update pulses once, select_wir never 1.
- wso path: in ShIR, drive wir_so pattern 1,0,1,1 -> wso shows 1,0,1,1 delayed one cycle, wso_en=1. wso_en drops one cycle after leaving ShIR.
- TMS reset: from PauIR, tms=1 x5 -> tap_state=F. With WSP_TLR_RESETN_EN, resetn=0 in TLR; without it, resetn stays 1.
- Async reset mid-ShDR: WRSTN low between edges -> strobes and wso_en drop immediately with no wdr_update pulse. Recovery from TLR is normal.

Source files
------------

// File: rtl/wsp_tap_ctrl.sv
// wsp_tap_ctrl: wrapper serial port controller.
// Runs an IEEE 1149.1 TAP state machine on WRCK and decodes the WIR and
// wrapper data register strobes.
// It steers wsi into both chains and muxes the selected chain onto a
// registered wso.
// Optional feature macro: WSP_TLR_RESETN_EN. When it is defined, resetn is
// low whenever the TAP sits in Test-Logic-Reset. When it is undefined,
// resetn is tied high.
module wsp_tap_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             WRCK,
  input  logic             WRSTN,
  input  logic             tms,
  input  logic             wsi,
  input  logic             wir_so,
  input  logic             wdr_so,
  output logic             select_wir,
  output logic             wir_si,
  output logic             wir_capture,
  output logic             wir_shift,
  output logic             wir_update,
  output logic             wdr_si,
  output logic             wdr_capture,
  output logic             wdr_shift,
  output logic             wdr_update,
  output logic             resetn,
  output logic             wso,
  output logic             wso_en,
  output logic [CNT_W-1:0] shift_count,
  output logic [3:0]       tap_state
);

  typedef enum logic [3:0] {
    S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PAUDR = 4'h3,
    S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7,
    S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PAUIR = 4'hB,
    S_RTI   = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF
  } tap_state_t;

  logic [1:0]       r_rst_sync;
  tap_state_t       r_state;
  tap_state_t       w_next;
  tap_state_t       w_state_d;
  logic             w_rel;
  logic             w_in_shift;
  logic             w_enter_cap;
  logic             r_wso;
  logic             r_wso_en;
  logic [CNT_W-1:0] r_cnt;

  assign w_rel = r_rst_sync[1];

  // Two-flop release of WRSTN so the TAP only starts walking on a clean edge.
  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Standard TAP next-state function driven by tms.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:   w_next = tms ? S_TLR   : S_RTI;
      S_RTI:   w_next = tms ? S_SELDR : S_RTI;
      S_SELDR: w_next = tms ? S_SELIR : S_CAPDR;
      S_CAPDR: w_next = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = tms ? S_UPDDR : S_PAUDR;
      S_PAUDR: w_next = tms ? S_EX2DR : S_PAUDR;
      S_EX2DR: w_next = tms ? S_UPDDR : S_SHDR;
      S_UPDDR: w_next = tms ? S_SELDR : S_RTI;
      S_SELIR: w_next = tms ? S_TLR   : S_CAPIR;
      S_CAPIR: w_next = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = tms ? S_UPDIR : S_PAUIR;
      S_PAUIR: w_next = tms ? S_EX2IR : S_PAUIR;
      S_EX2IR: w_next = tms ? S_UPDIR : S_SHIR;
      S_UPDIR: w_next = tms ? S_SELDR : S_RTI;
      default: w_next = S_TLR;
    endcase
    // Until the release synchroniser has settled, the TAP is pinned in TLR.
    if (w_rel) begin
      w_state_d = w_next;
    end else begin
      w_state_d = S_TLR;
    end
  end

  // TAP state register.
  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      r_state <= S_TLR;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Moore decode of strobes and column select from the state register.
  always_comb begin
    select_wir  = 1'b0;
    wir_capture = 1'b0;
    wir_shift   = 1'b0;
    wir_update  = 1'b0;
    wdr_capture = 1'b0;
    wdr_shift   = 1'b0;
    wdr_update  = 1'b0;
    case (r_state)
      S_SELIR, S_EX1IR, S_PAUIR, S_EX2IR: select_wir = 1'b1;
      S_CAPIR: begin select_wir = 1'b1; wir_capture = 1'b1; end
      S_SHIR:  begin select_wir = 1'b1; wir_shift   = 1'b1; end
      S_UPDIR: begin select_wir = 1'b1; wir_update  = 1'b1; end
      S_CAPDR: wdr_capture = 1'b1;
      S_SHDR:  wdr_shift   = 1'b1;
      S_UPDDR: wdr_update  = 1'b1;
      default: select_wir  = 1'b0;
    endcase
  end

  assign w_in_shift  = (r_state == S_SHIR) || (r_state == S_SHDR);
  assign w_enter_cap = (w_state_d == S_CAPIR) || (w_state_d == S_CAPDR);

  // Serial output: capture the selected chain's so on every shift edge.
  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      r_wso    <= 1'b0;
      r_wso_en <= 1'b0;
    end else begin
      r_wso_en <= w_in_shift;
      if (w_in_shift) begin
        r_wso <= select_wir ? wir_so : wdr_so;
      end else begin
        r_wso <= r_wso;
      end
    end
  end

  // Shift-bit counter: cleared on entering Capture, saturating count of shift edges.
  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_enter_cap) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_in_shift && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

`ifdef WSP_TLR_RESETN_EN
  // TLR (including the asynchronous reset state) holds the WIR in reset.
  assign resetn = (r_state != S_TLR);
`else
  assign resetn = 1'b1;
`endif

  assign wir_si      = wsi;
  assign wdr_si      = wsi;
  assign wso         = r_wso;
  assign wso_en      = r_wso_en;
  assign shift_count = r_cnt;
  assign tap_state   = r_state;

endmodule
